// File: rtl/fpu_pipe_pkg.sv
// Shared definitions for the FPU pipeline register chain.
// Provides the default datapath width and a width helper.
package fpu_pipe_pkg;

    localparam int DEF_WIDTH = 32;

    function automatic int clog2_safe(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: data register plus valid bit.
// Readiness is passed through combinationally from downstream.
module pipe_stage
    import fpu_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load;

    assign ready = !valid_q || down_ready;
    assign load  = up_valid && ready;

    // Flush wins over a load and leaves the data register untouched.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = up_data;
        end else if (down_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of STAGES elastic pipeline registers with flush and
// a registered occupancy count.
module pipe_reg_chain
    import fpu_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic [clog2_safe(STAGES+1)-1:0]     count
);

    localparam int CW = clog2_safe(STAGES + 1);

    logic          push;
    logic          pop;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_r;
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic             rdy;

        if (i == 0) begin : g_head
            assign up_v = push;
            assign up_d = in_data;
        end else begin : g_link
            assign up_v = g_stage[i-1].vld;
            assign up_d = g_stage[i-1].dat;
        end

        if (i == STAGES - 1) begin : g_tail
            assign dn_r = out_ready;
        end else begin : g_mid
            assign dn_r = g_stage[i+1].rdy;
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (up_v),
            .up_data    (up_d),
            .down_ready (dn_r),
            .valid      (vld),
            .data       (dat),
            .ready      (rdy)
        );
    end

    // Neither handshake may complete during reset or a flush cycle.
    assign in_ready  = g_stage[0].rdy && !flush && !rst;
    assign out_valid = g_stage[STAGES-1].vld && !flush;
    assign out_data  = g_stage[STAGES-1].dat;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
